// File: rtl/vga_scan_out_pkg.sv
// Shared VGA constants: colour bit order, TinyVGA PMOD bit positions and default 640x480@60 timing.
package vga_scan_out_pkg;

  // Colour word from the flag modules: {R1,R0,G1,G0,B1,B0}
  localparam int C_R1 = 5;
  localparam int C_R0 = 4;
  localparam int C_G1 = 3;
  localparam int C_G0 = 2;
  localparam int C_B1 = 1;
  localparam int C_B0 = 0;

  // PMOD byte: {hsync,B0,G0,R0,vsync,B1,G1,R1}
  localparam int P_HSYNC = 7;
  localparam int P_B0    = 6;
  localparam int P_G0    = 5;
  localparam int P_R0    = 4;
  localparam int P_VSYNC = 3;
  localparam int P_B1    = 2;
  localparam int P_G1    = 1;
  localparam int P_R1    = 0;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  typedef struct packed {
    logic hsync;       // active low
    logic vsync;       // active low
    logic display_on;
  } sync_t;

  function automatic logic [7:0] pmod_pack(input logic [5:0] rgb, input logic hs, input logic vs);
    logic [7:0] b;
    b          = '0;
    b[P_HSYNC] = hs;
    b[P_VSYNC] = vs;
    b[P_R1]    = rgb[C_R1];
    b[P_R0]    = rgb[C_R0];
    b[P_G1]    = rgb[C_G1];
    b[P_G0]    = rgb[C_G0];
    b[P_B1]    = rgb[C_B1];
    b[P_B0]    = rgb[C_B0];
    return b;
  endfunction

endpackage

// File: rtl/vga_scan_out_sync_counter.sv
// h/v scan counters with wrap logic plus display-area and sync-pulse decodes.
module vga_sync_counter
  import vga_scan_out_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       frame_wrap,
  output sync_t      sync
);

  localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic line_wrap;

  assign line_wrap  = (h == H_LAST);
  assign frame_wrap = line_wrap && (v == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (line_wrap) begin
      h <= '0;
      v <= frame_wrap ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  always_comb begin
    sync.display_on = (h < H_VIS) && (v < V_VIS);
    sync.hsync      = ~((h >= HS_START) && (h <= HS_END));
    sync.vsync      = ~((v >= VS_START) && (v <= VS_END));
  end

endmodule

// File: rtl/vga_scan_out.sv
// 640x480 scan-out: coordinates to the flag modules, registered colour+sync onto the PMOD byte.
module vga_scan_out
  import vga_scan_out_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] color,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       display_on,
  output logic [7:0] frame,
  output logic       frame_start,
  output logic [7:0] vga_out
);

  sync_t sync;
  logic  frame_wrap;

  vga_sync_counter #(
    .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .h          (pix_x),
    .v          (pix_y),
    .frame_wrap (frame_wrap),
    .sync       (sync)
  );

  assign display_on  = sync.display_on;
  assign frame_start = (pix_x == 10'd0) && (pix_y == 10'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           frame <= '0;
    else if (frame_wrap) frame <= frame + 8'd1;
  end

  // Colour and syncs share one register so their alignment on the pins is exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vga_out <= pmod_pack(6'd0, 1'b1, 1'b1);
    else       vga_out <= pmod_pack(sync.display_on ? color : 6'd0, sync.hsync, sync.vsync);
  end

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboard bench for vga_scan_out, run with reduced timing so full frames stay short.
module tb_vga_scan_out;

  localparam int HD = 16, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;  // 23
  localparam int VT = VD + VF + VS + VB;  // 13

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] color = '0;
  logic [9:0] pix_x, pix_y;
  logic       display_on, frame_start;
  logic [7:0] frame, vga_out;

  vga_scan_out #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .color(color),
    .pix_x(pix_x), .pix_y(pix_y), .display_on(display_on),
    .frame(frame), .frame_start(frame_start), .vga_out(vga_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int mx = 0, my = 0, mf = 0;
  logic [7:0] exp_q[$];
  int hs_low, vs_low, vis_ff, fs_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)", tag, got, exp, mx, my);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [5:0] c, input int x, input int y);
    logic       vis, hs, vs;
    logic [5:0] r;
    vis = (x < HD) && (y < VD);
    hs  = !((x >= HD + HF) && (x <= HD + HF + HS - 1));
    vs  = !((y >= VD + VF) && (y <= VD + VF + VS - 1));
    r   = vis ? c : 6'd0;
    return {hs, r[0], r[2], r[4], vs, r[1], r[3], r[5]};
  endfunction

  // One pixel: drive colour, check the combinational decodes, queue the expected
  // PMOD byte, then compare it one edge later.
  task automatic step(input logic [5:0] c);
    logic [7:0] e;
    color = c;
    @(negedge clk);
    chk("pix_x", pix_x, mx);
    chk("pix_y", pix_y, my);
    chk("display_on", display_on, (mx < HD) && (my < VD));
    chk("frame_start", frame_start, (mx == 0) && (my == 0));
    chk("frame", frame, mf & 255);
    if (frame_start) fs_cnt++;
    exp_q.push_back(exp_byte(c, mx, my));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk("queue_empty", 1, 0);
    else begin
      e = exp_q.pop_front();
      chk("vga_out", vga_out, e);
    end
    if (vga_out[7] == 1'b0) hs_low++;
    if (vga_out[3] == 1'b0) vs_low++;
    if (vga_out == 8'hFF) vis_ff++;
    if (mx == HT - 1) begin
      mx = 0;
      if (my == VT - 1) begin my = 0; mf++; end
      else my++;
    end else mx++;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_vga"}, vga_out, 8'h88);
    chk({tag, "_x"}, pix_x, 0);
    chk({tag, "_y"}, pix_y, 0);
    chk({tag, "_don"}, display_on, 1);
    chk({tag, "_fs"}, frame_start, 1);
    chk({tag, "_frame"}, frame, 0);
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1'b0;
    mx = 0; my = 0; mf = 0;

    // First pixel after release carries the colour-mapped (0,0) with syncs high.
    step(6'b10_01_11);
    chk("color_map", vga_out, 8'hED);

    // Two lines of random colour: hsync low exactly HS clocks per line.
    hs_low = 0;
    for (int i = 1; i < 2 * HT; i++) step(6'($urandom));
    chk("hsync_low_2lines", hs_low, 2 * HS);

    // Finish the frame with full white: blanking and vsync width.
    vs_low = 0; vis_ff = 0; fs_cnt = 0;
    while (!(mx == 0 && my == 0)) step(6'h3F);
    chk("frame_after_1", frame, 1);
    chk("frame_start_at_wrap", frame_start, 1);

    // A full frame from (0,0) with white: counts are all derived from the timing.
    vs_low = 0; vis_ff = 0; fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) step(6'h3F);
    chk("vsync_low_frame", vs_low, VS * HT);
    chk("visible_white", vis_ff, HD * VD);
    chk("frame_start_once", fs_cnt, 1);
    chk("frame_after_2", frame, 2);

    // Mid-frame reset at a scaled (700,300) point, inside the hsync pulse.
    guard = 0;
    while (!(mx == HD + HF + 2 && my == 4) && guard < 2 * HT * VT) begin
      step(6'($urandom));
      guard++;
    end
    chk("midreset_reached", guard < 2 * HT * VT, 1);
    chk("midreset_pre_hs", vga_out[7], 0);
    reset = 1'b1;
    #1;
    check_reset_state("mid");
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("mid_hold");
    reset = 1'b0;
    exp_q.delete();
    mx = 0; my = 0; mf = 0;
    for (int i = 0; i < HT * VT + 5; i++) step(6'($urandom));
    chk("frame_after_restart", frame, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
